// File: rtl/gprf_bus1_master_pkg.sv
// -----------------------------------------------------------------------------
// gprf_bus1_master_pkg
// Shared constants for the bus1 initiator of the general-purpose register file:
//   GPRF_DAT_W : bus1 data width (matches the register file data width)
//   GPRF_NREG  : number of addressable registers (r0..r19)
//   IDX_W      : width of a register index on the command interface
//   OP_*       : command operation encodings
//   state_t    : initiator FSM state encoding
// -----------------------------------------------------------------------------
package gprf_bus1_master_pkg;

   localparam int GPRF_DAT_W = 16;
   localparam int GPRF_NREG  = 20;
   localparam int IDX_W      = 5;

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_READ = 2'd1;
   localparam logic [1:0] OP_MOVE = 2'd2;
   localparam logic [1:0] OP_RSVD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

endpackage

// File: rtl/gprf_bus1_master_if.sv
// -----------------------------------------------------------------------------
// gprf_bus1_master_if
// Bundles the command, response and bus1 register-file signals of the
// gprf bus1 initiator.
//   command  : cmd_valid/cmd_ready handshake, cmd_op, cmd_src, cmd_dst, cmd_imm
//   response : rsp_valid/rsp_ready handshake, rsp_dat, rsp_err
//   bus1     : bus1_t_sel (one-hot write strobe), bus1_r_sel (one-hot read
//              strobe), bus1_dat (write data), bus1_gprf_r_dat (read data)
// Modports:
//   master : the initiator block itself
//   slave  : its environment (sequencer, response consumer and gprf)
// -----------------------------------------------------------------------------
interface gprf_bus1_master_if
   import gprf_bus1_master_pkg::*;
#(
   parameter int DAT_W = GPRF_DAT_W,
   parameter int NREG  = GPRF_NREG
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [IDX_W-1:0] cmd_src;
   logic [IDX_W-1:0] cmd_dst;
   logic [DAT_W-1:0] cmd_imm;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [DAT_W-1:0] rsp_dat;
   logic             rsp_err;

   logic [NREG-1:0]  bus1_t_sel;
   logic [NREG-1:0]  bus1_r_sel;
   logic [DAT_W-1:0] bus1_dat;
   logic [DAT_W-1:0] bus1_gprf_r_dat;

   modport master (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      output cmd_ready,
      output rsp_valid, rsp_dat, rsp_err,
      input  rsp_ready,
      output bus1_t_sel, bus1_r_sel, bus1_dat,
      input  bus1_gprf_r_dat
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
      input  cmd_ready,
      input  rsp_valid, rsp_dat, rsp_err,
      output rsp_ready,
      input  bus1_t_sel, bus1_r_sel, bus1_dat,
      output bus1_gprf_r_dat
   );

endinterface

// File: rtl/gprf_idx_dec.sv
// -----------------------------------------------------------------------------
// gprf_idx_dec
// Register index decoder: turns a 5-bit register index into a one-hot select
// vector and flags indices that do not address an existing register.
// Ports:
//   idx    in  IDX_W  register index
//   en     in  1      enable; onehot is all-zero when low
//   onehot out NREG   one-hot select (zero when disabled or out of range)
//   oor    out 1      index >= NREG (independent of en)
// -----------------------------------------------------------------------------
module gprf_idx_dec
   import gprf_bus1_master_pkg::*;
#(
   parameter int NREG = GPRF_NREG
) (
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [NREG-1:0]  onehot,
   output logic             oor
);

   // oor is kept out of the always_comb below: the parent derives en from it,
   // so sharing one process would form a false combinational loop.
   assign oor = (32'(idx) >= 32'(NREG));

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NREG; i++) begin
         if (en && (idx == IDX_W'(i))) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gprf_bus1_master.sv
// -----------------------------------------------------------------------------
// gprf_bus1_master
// Bus1 initiator for the general-purpose register file. Accepts LOAD / READ /
// MOVE commands from the instruction sequencer, drives the one-hot per-register
// read/write strobes and write data onto bus1, samples the register file's
// read data and returns one response per command.
// Parameters:
//   DAT_W  : bus1 data width
//   NREG   : number of registers addressed
//   RD_LAT : cycles from r_sel assertion to valid read data (0..3)
// Ports:
//   clk    in  clock, rising edge
//   rst_b  in  synchronous reset, active-high
//   bus    master modport of gprf_bus1_master_if (command, response, bus1)
// -----------------------------------------------------------------------------
module gprf_bus1_master
   import gprf_bus1_master_pkg::*;
#(
   parameter int DAT_W  = GPRF_DAT_W,
   parameter int NREG   = GPRF_NREG,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_b,
   gprf_bus1_master_if.master bus
);

   localparam int CNT_W = 2;

   state_t           state;
   logic [1:0]       op_q;
   logic [IDX_W-1:0] dst_q;
   logic [DAT_W-1:0] dat_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             rd_last;
   logic             cmd_err;
   logic             src_en;
   logic             dst_en;
   logic [IDX_W-1:0] dst_idx;
   logic [NREG-1:0]  src_oh;
   logic [NREG-1:0]  dst_oh;
   logic             src_oor;
   logic             dst_oor;

   assign accept  = (state == ST_IDLE) && bus.cmd_ready && bus.cmd_valid;
   assign rd_last = (state == ST_RD) && (cnt_q == '0);

   // Read strobe is only ever launched at accept, so the source decoder always
   // looks at the live command index.
   assign src_en = accept && !cmd_err &&
                   ((bus.cmd_op == OP_READ) || (bus.cmd_op == OP_MOVE));

   // The destination decoder serves two moments: the LOAD write launched at
   // accept (live command index) and the MOVE write launched at the end of the
   // read phase (registered index).
   assign dst_idx = (state == ST_IDLE) ? bus.cmd_dst : dst_q;
   assign dst_en  = accept ? (!cmd_err && (bus.cmd_op == OP_LOAD))
                           : (rd_last && (op_q == OP_MOVE));

   gprf_idx_dec #(.NREG(NREG)) u_src_dec (
      .idx    (bus.cmd_src),
      .en     (src_en),
      .onehot (src_oh),
      .oor    (src_oor)
   );

   gprf_idx_dec #(.NREG(NREG)) u_dst_dec (
      .idx    (dst_idx),
      .en     (dst_en),
      .onehot (dst_oh),
      .oor    (dst_oor)
   );

   // Only indices the operation actually uses are range-checked.
   always_comb begin
      case (bus.cmd_op)
         OP_LOAD: cmd_err = dst_oor;
         OP_READ: cmd_err = src_oor;
         OP_MOVE: cmd_err = src_oor | dst_oor;
         default: cmd_err = 1'b1;
      endcase
   end

   // ---- command capture / read data capture ----
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q  <= bus.cmd_op;
         dst_q <= bus.cmd_dst;
      end
      if (rd_last) begin
         dat_q <= bus.bus1_gprf_r_dat;
      end
   end

   // ---- control FSM with registered outputs ----
   always_ff @(posedge clk) begin
      if (rst_b) begin
         state          <= ST_IDLE;
         cnt_q          <= '0;
         bus.cmd_ready  <= 1'b0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_dat    <= '0;
         bus.rsp_err    <= 1'b0;
         bus.bus1_t_sel <= '0;
         bus.bus1_r_sel <= '0;
         bus.bus1_dat   <= '0;
      end else begin
         // Write strobe and write data are single-cycle pulses by default.
         bus.bus1_t_sel <= '0;
         bus.bus1_dat   <= '0;

         case (state)
            ST_IDLE: begin
               bus.cmd_ready <= 1'b1;
               if (accept) begin
                  bus.cmd_ready <= 1'b0;
                  cnt_q         <= CNT_W'(RD_LAT);
                  if (cmd_err) begin
                     state         <= ST_RSP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_dat   <= '0;
                  end else if (bus.cmd_op == OP_LOAD) begin
                     state          <= ST_WR;
                     bus.bus1_t_sel <= dst_oh;
                     bus.bus1_dat   <= bus.cmd_imm;
                  end else begin
                     state          <= ST_RD;
                     bus.bus1_r_sel <= src_oh;
                  end
               end
            end

            ST_RD: begin
               // r_sel stays up for RD_LAT+1 cycles; data is sampled in the last.
               if (cnt_q == '0) begin
                  bus.bus1_r_sel <= '0;
                  if (op_q == OP_MOVE) begin
                     state          <= ST_WR;
                     bus.bus1_t_sel <= dst_oh;
                     bus.bus1_dat   <= bus.bus1_gprf_r_dat;
                  end else begin
                     state         <= ST_RSP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b0;
                     bus.rsp_dat   <= bus.bus1_gprf_r_dat;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            ST_WR: begin
               state         <= ST_RSP;
               bus.rsp_valid <= 1'b1;
               bus.rsp_err   <= 1'b0;
               bus.rsp_dat   <= (op_q == OP_MOVE) ? dat_q : '0;
            end

            ST_RSP: begin
               if (bus.rsp_ready) begin
                  state         <= ST_IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_dat   <= '0;
                  bus.rsp_err   <= 1'b0;
                  bus.cmd_ready <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gprf_bus1_master.sv
// -----------------------------------------------------------------------------
// tb_gprf_bus1_master
// Directed bench for gprf_bus1_master with RD_LAT = 1 and a behavioural
// register file (registered read port, one cycle read latency).
// -----------------------------------------------------------------------------
module tb_gprf_bus1_master;
   import gprf_bus1_master_pkg::*;

   localparam int DW  = 16;
   localparam int NR  = 20;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst_b;
   logic gprf_clr;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   gprf_bus1_master_if #(.DAT_W(DW), .NREG(NR)) bus ();

   gprf_bus1_master #(.DAT_W(DW), .NREG(NR), .RD_LAT(LAT)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   // behavioural register file
   logic [DW-1:0] regs [NR];
   logic [DW-1:0] rd_q;

   always @(posedge clk) begin
      if (gprf_clr) begin
         for (int i = 0; i < NR; i++) regs[i] <= DW'(16'h0A00 + i);
         rd_q <= '0;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (bus.bus1_t_sel[i]) regs[i] <= bus.bus1_dat;
         end
         rd_q <= '0;
         for (int i = 0; i < NR; i++) begin
            if (bus.bus1_r_sel[i]) rd_q <= regs[i];
         end
      end
   end

   assign bus.bus1_gprf_r_dat = rd_q;

   // strobe monitor, sampled mid-cycle
   int            t_cnt [NR];
   int            r_cnt [NR];
   logic [DW-1:0] t_dat [NR];
   int            strobe_cyc = 0;
   int            strobe_viol = 0;
   int            dat_viol = 0;

   initial begin
      for (int i = 0; i < NR; i++) begin
         t_cnt[i] = 0;
         r_cnt[i] = 0;
         t_dat[i] = '0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NR; i++) begin
         if (bus.bus1_t_sel[i]) begin
            t_cnt[i] <= t_cnt[i] + 1;
            t_dat[i] <= bus.bus1_dat;
         end
         if (bus.bus1_r_sel[i]) r_cnt[i] <= r_cnt[i] + 1;
      end
      if ((bus.bus1_t_sel | bus.bus1_r_sel) != '0) strobe_cyc <= strobe_cyc + 1;
      if ($countones({bus.bus1_t_sel, bus.bus1_r_sel}) > 1) strobe_viol <= strobe_viol + 1;
      if ((bus.bus1_t_sel == '0) && (bus.bus1_dat != '0)) dat_viol <= dat_viol + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the command until accepted; leaves time at accept edge + 1.
   task automatic issue(input logic [1:0] op, input logic [4:0] src,
                        input logic [4:0] dst, input logic [DW-1:0] imm);
      int n = 0;
      bus.cmd_op    = op;
      bus.cmd_src   = src;
      bus.cmd_dst   = dst;
      bus.cmd_imm   = imm;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (!bus.cmd_ready) $display("FAIL accept_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
      else passed++;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Returns accept-edge-to-rsp_valid latency in cycles.
   task automatic wait_rsp(output int lat);
      int n = 0;
      while (!bus.rsp_valid && n < 30) begin
         tick();
         n++;
      end
      total++;
      if (!bus.rsp_valid) $display("FAIL rsp_timeout: rsp_valid=%0b required 1", bus.rsp_valid);
      else passed++;
      lat = n + 1;
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_b    = 1'b1;
      gprf_clr = 1'b1;
      repeat (10) tick();
      total++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err} !== 3'b000)
         $display("FAIL reset_ctrl: ready/valid/err=%b required 000", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err});
      else passed++;
      total++;
      if ({bus.bus1_t_sel, bus.bus1_r_sel, bus.bus1_dat, bus.rsp_dat} !== '0)
         $display("FAIL reset_bus: t_sel=%h r_sel=%h dat=%h rsp_dat=%h required 0",
                  bus.bus1_t_sel, bus.bus1_r_sel, bus.bus1_dat, bus.rsp_dat);
      else passed++;
      rst_b    = 1'b0;
      gprf_clr = 1'b0;
      #2;
      total++;
      if (bus.cmd_ready !== 1'b0) $display("FAIL ready_at_release: got %b required 0", bus.cmd_ready);
      else passed++;
      tick();
      total++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL ready_after_release: got %b required 1", bus.cmd_ready);
      else passed++;
   endtask

   task automatic test_load_read();
      int lat;
      int t0, r0;
      t0 = t_cnt[0];
      issue(OP_LOAD, 5'd0, 5'd0, 16'h0001);
      wait_rsp(lat);
      total++;
      if (lat !== 2) $display("FAIL load_latency: got %0d required 2", lat);
      else passed++;
      total++;
      if ({bus.rsp_err, bus.rsp_dat} !== {1'b0, 16'h0000})
         $display("FAIL load_rsp: err=%b dat=%h required err=0 dat=0000", bus.rsp_err, bus.rsp_dat);
      else passed++;
      total++;
      if ((t_cnt[0] - t0) !== 1 || t_dat[0] !== 16'h0001)
         $display("FAIL load_tsel0: pulses=%0d dat=%h required 1 pulse dat=0001", t_cnt[0] - t0, t_dat[0]);
      else passed++;
      consume();
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
         $display("FAIL load_consume: ready=%b valid=%b required 1/0", bus.cmd_ready, bus.rsp_valid);
      else passed++;

      r0 = r_cnt[0];
      issue(OP_READ, 5'd0, 5'd0, 16'h0);
      wait_rsp(lat);
      total++;
      if (lat !== LAT + 2) $display("FAIL read_latency: got %0d required %0d", lat, LAT + 2);
      else passed++;
      total++;
      if ({bus.rsp_err, bus.rsp_dat} !== {1'b0, 16'h0001})
         $display("FAIL read_r0: err=%b dat=%h required err=0 dat=0001", bus.rsp_err, bus.rsp_dat);
      else passed++;
      total++;
      if ((r_cnt[0] - r0) !== LAT + 1) $display("FAIL read_rsel_len: got %0d required %0d", r_cnt[0] - r0, LAT + 1);
      else passed++;
      consume();
   endtask

   task automatic test_move();
      int lat;
      int t5, t19;
      issue(OP_LOAD, 5'd0, 5'd19, 16'h0003);
      wait_rsp(lat);
      consume();
      total++;
      if (regs[19] !== 16'h0003) $display("FAIL load_r19: got %h required 0003", regs[19]);
      else passed++;

      t5  = t_cnt[5];
      t19 = t_cnt[19];
      issue(OP_MOVE, 5'd19, 5'd5, 16'h0);
      wait_rsp(lat);
      total++;
      if (lat !== LAT + 3) $display("FAIL move_latency: got %0d required %0d", lat, LAT + 3);
      else passed++;
      total++;
      if ({bus.rsp_err, bus.rsp_dat} !== {1'b0, 16'h0003})
         $display("FAIL move_rsp: err=%b dat=%h required err=0 dat=0003", bus.rsp_err, bus.rsp_dat);
      else passed++;
      total++;
      if ((t_cnt[5] - t5) !== 1 || t_dat[5] !== 16'h0003)
         $display("FAIL move_tsel5: pulses=%0d dat=%h required 1 pulse dat=0003", t_cnt[5] - t5, t_dat[5]);
      else passed++;
      total++;
      if ((t_cnt[19] - t19) !== 0) $display("FAIL move_no_tsel19: got %0d pulses required 0", t_cnt[19] - t19);
      else passed++;
      consume();

      issue(OP_READ, 5'd5, 5'd0, 16'h0);
      wait_rsp(lat);
      total++;
      if (bus.rsp_dat !== 16'h0003) $display("FAIL read_r5: got %h required 0003", bus.rsp_dat);
      else passed++;
      consume();

      // source equal to destination rewrites the same value
      t19 = t_cnt[19];
      issue(OP_MOVE, 5'd19, 5'd19, 16'h0);
      wait_rsp(lat);
      total++;
      if (bus.rsp_err !== 1'b0 || bus.rsp_dat !== 16'h0003 || (t_cnt[19] - t19) !== 1 || regs[19] !== 16'h0003)
         $display("FAIL move_self: err=%b dat=%h pulses=%0d r19=%h required 0/0003/1/0003",
                  bus.rsp_err, bus.rsp_dat, t_cnt[19] - t19, regs[19]);
      else passed++;
      consume();
   endtask

   task automatic test_errors();
      int lat;
      int s0;
      logic [1:0] ops [4];
      logic [4:0] srcs [4];
      logic [4:0] dsts [4];
      ops  = '{OP_LOAD, OP_RSVD, OP_READ, OP_MOVE};
      srcs = '{5'd0,    5'd0,    5'd31,   5'd0};
      dsts = '{5'd20,   5'd1,    5'd0,    5'd25};
      for (int k = 0; k < 4; k++) begin
         s0 = strobe_cyc;
         issue(ops[k], srcs[k], dsts[k], 16'h0055);
         wait_rsp(lat);
         total++;
         if (lat !== 1 || bus.rsp_err !== 1'b1 || bus.rsp_dat !== 16'h0000)
            $display("FAIL err_case%0d: lat=%0d err=%b dat=%h required 1/1/0000", k, lat, bus.rsp_err, bus.rsp_dat);
         else passed++;
         consume();
         repeat (2) tick();
         total++;
         if (strobe_cyc !== s0) $display("FAIL err_nostrobe%0d: strobe cycles=%0d required 0", k, strobe_cyc - s0);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int t1;
      logic stable_ok = 1'b1;
      issue(OP_READ, 5'd0, 5'd0, 16'h0);
      wait_rsp(lat);
      t1 = t_cnt[1];
      bus.cmd_op    = OP_LOAD;
      bus.cmd_src   = 5'd0;
      bus.cmd_dst   = 5'd1;
      bus.cmd_imm   = 16'h0007;
      bus.cmd_valid = 1'b1;
      repeat (5) begin
         tick();
         if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 16'h0001 || bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0)
            stable_ok = 1'b0;
      end
      total++;
      if (stable_ok !== 1'b1) $display("FAIL bp_stable: stable=%b required 1", stable_ok);
      else passed++;
      consume();
      total++;
      if (bus.cmd_ready !== 1'b1 || (t_cnt[1] - t1) !== 0)
         $display("FAIL bp_after_consume: ready=%b pulses=%0d required 1/0", bus.cmd_ready, t_cnt[1] - t1);
      else passed++;
      tick();
      bus.cmd_valid = 1'b0;
      total++;
      if (bus.cmd_ready !== 1'b0) $display("FAIL bp_held_accept: ready=%b required 0", bus.cmd_ready);
      else passed++;
      wait_rsp(lat);
      consume();
      total++;
      if ((t_cnt[1] - t1) !== 1 || regs[1] !== 16'h0007)
         $display("FAIL bp_load: pulses=%0d r1=%h required 1/0007", t_cnt[1] - t1, regs[1]);
      else passed++;
   endtask

   task automatic test_reset_mid_move();
      int t7;
      t7 = t_cnt[7];
      issue(OP_MOVE, 5'd0, 5'd7, 16'h0);
      total++;
      if (bus.bus1_r_sel !== NR'(1)) $display("FAIL midrst_in_rd: r_sel=%h required 00001", bus.bus1_r_sel);
      else passed++;
      rst_b = 1'b1;
      tick();
      total++;
      if ({bus.bus1_t_sel, bus.bus1_r_sel, bus.bus1_dat} !== '0 || bus.rsp_valid !== 1'b0)
         $display("FAIL midrst_drop: t_sel=%h r_sel=%h dat=%h valid=%b required all 0",
                  bus.bus1_t_sel, bus.bus1_r_sel, bus.bus1_dat, bus.rsp_valid);
      else passed++;
      tick();
      rst_b = 1'b0;
      repeat (5) tick();
      total++;
      if ((t_cnt[7] - t7) !== 0 || regs[7] !== 16'h0A07)
         $display("FAIL midrst_no_write: pulses=%0d r7=%h required 0/0a07", t_cnt[7] - t7, regs[7]);
      else passed++;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("FAIL midrst_idle: valid=%b ready=%b required 0/1", bus.rsp_valid, bus.cmd_ready);
      else passed++;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_src   = 5'd0;
      bus.cmd_dst   = 5'd0;
      bus.cmd_imm   = '0;
      bus.rsp_ready = 1'b0;
      rst_b         = 1'b1;
      gprf_clr      = 1'b1;

      test_reset();
      test_load_read();
      test_move();
      test_errors();
      test_backpressure();
      test_reset_mid_move();

      total++;
      if (strobe_viol !== 0 || dat_viol !== 0)
         $display("FAIL strobe_rules: multi-strobe cycles=%0d stray data cycles=%0d required 0/0", strobe_viol, dat_viol);
      else passed++;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gprf_bus1_master.md
Name: gprf_bus1_master

Overview:
- Bus1 initiator for the general-purpose register file (20 registers, r0..r19).
- Turns register-transfer commands into the per-register select strobes and data the register file consumes:
  - LOAD: immediate into register
  - READ: register out to requester
  - MOVE: register to register
- Sits between the instruction sequencer and gprf; its outputs wire one-to-one onto gprf's bus1_rN_t_sel / bus1_rN_r_sel / bus1_dat, and it samples bus1_gprf_r_dat.

Parameters:
- DAT_W, 16, bus1 data width; must equal the `DAT_W define.
- NREG, 20, number of registers addressed.
- RD_LAT, 1, cycles from r_sel assertion to valid bus1_gprf_r_dat; legal range 0..3.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_b  in  1  reset; synchronous, active-high (1 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  2  operation: 0 = LOAD, 1 = READ, 2 = MOVE, 3 = reserved.
- cmd_src  in  5  source register index (READ, MOVE).
- cmd_dst  in  5  destination register index (LOAD, MOVE).
- cmd_imm  in  DAT_W  immediate for LOAD.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_dat  out  DAT_W  READ/MOVE data; 0 for LOAD.
- rsp_err  out  1  illegal op or index ≥ NREG.
- bus1_t_sel  out  NREG  one-hot write strobe; bit N drives bus1_rN_t_sel.
- bus1_r_sel  out  NREG  one-hot read strobe; bit N drives bus1_rN_r_sel.
- bus1_dat  out  DAT_W  write data to gprf.
- bus1_gprf_r_dat  in  DAT_W  read data from gprf.

Behaviour:
- Reset values:
  - cmd_ready = 0.
  - rsp_valid = 0, rsp_dat = 0, rsp_err = 0.
  - bus1_t_sel = 0, bus1_r_sel = 0, bus1_dat = 0.
  - FSM goes to IDLE, and cmd_ready rises the cycle after rst_b deasserts.
- Handshakes:
  - A command is accepted when cmd_valid && cmd_ready. cmd_ready = 1 only in IDLE.
  - The response is consumed when rsp_valid && rsp_ready. rsp_* hold stable until consumed.
- FSM states: IDLE, RD, WR, RSP.
  - IDLE, on accept:
    - Register op, src, dst and imm.
    - Error check: if op = 3, or any index the op uses is ≥ NREG, go to RSP with rsp_err = 1 and rsp_dat = 0. No strobes are issued.
    - LOAD goes to WR. READ and MOVE go to RD.
  - RD:
    - bus1_r_sel[src] = 1 for RD_LAT + 1 cycles. A counter counts down from RD_LAT.
    - In the last cycle, capture bus1_gprf_r_dat into the data register.
    - Then READ goes to RSP, and MOVE goes to WR.
  - WR:
    - One cycle with bus1_t_sel[dst] = 1 and bus1_dat = captured data (MOVE) or imm (LOAD).
    - Then go to RSP.
  - RSP:
    - rsp_valid = 1, rsp_dat = data (0 for LOAD).
    - On consume, go to IDLE; cmd_ready = 1 the following cycle.
- Strobe rules:
  - At most one bit set across bus1_t_sel | bus1_r_sel in any cycle; t_sel and r_sel are never both asserted.
  - bus1_dat = 0 whenever no t_sel bit is set.
  - All strobe and data outputs are registered (no combinational path from cmd_* to bus1_*).
- Latency, accept edge to rsp_valid:
  - LOAD: 2 cycles.
  - READ: RD_LAT + 2 cycles.
  - MOVE: RD_LAT + 3 cycles.
- Boundary cases:
  - MOVE with src = dst is legal: the register is read, then rewritten with the same value.
  - Index 19 is legal; index 20..31 gives an error.
  - rst_b asserted mid-operation drops all strobes at the next edge. No partial write is completed and the pending response is discarded.
  - A cmd_valid held during busy states is ignored and not latched.

Decomposition:
- Shared package/define file holds:
  - DAT_W and NREG.
  - Op encodings OP_LOAD, OP_READ, OP_MOVE.
  - State encodings.
- Sub-module gprf_idx_dec (5-bit index + enable → NREG one-hot, plus out-of-range flag), instantiated twice: src/r_sel and dst/t_sel.

Test Plan:
- Reset: rst_b = 1 for 10 cycles, then 0 → all bus1_* = 0, rsp_valid = 0, and cmd_ready = 1 one cycle after release.
- LOAD dst = 0, imm = 1:
  - t_sel[0] = 1 with bus1_dat = 1 for exactly one cycle.
  - Then READ src = 0 → r_sel[0] held RD_LAT + 1 cycles, rsp_dat = 1, rsp_err = 0.
- LOAD r19 = 3, then MOVE 19 → 5, then READ r5:
  - rsp_dat = 3.
  - t_sel[5] pulse carries bus1_dat = 3.
  - No t_sel[19] during the MOVE.
- Error cases:
  - cmd_dst = 20 with LOAD → rsp_err = 1, rsp_dat = 0, and no strobe bit ever set.
  - op = 3 → same response.
- Backpressure: hold rsp_ready = 0 for 5 cycles after a READ → rsp_* stable, cmd_ready = 0, and the held cmd_valid is not accepted until one cycle after consume.
- Reset mid-MOVE: assert rst_b during RD → no t_sel pulse follows and the destination register is unchanged (verified with gprf instantiated).
